// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding and default frame width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (start + DATA_BITS + [parity] + stop, LSB first) with valid/ready output.
// Optional parity bit and parity_err enabled by macro UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
`ifdef UART_RX_PARITY_EN
    ,
    parameter int unsigned PARITY_ODD   = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_STOP   = 3'(STOP);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'(PARITY);
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic                 rx_s;
    logic [2:0]           state, state_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n;
    logic                 frame_err_n;
    logic                 overrun_n;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_n;
    logic                 parity_err_n;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt + 1'b1;
        idx_n       = idx;
        shreg_n     = shreg;
        rx_data_n   = rx_data;
        rx_valid_n  = rx_valid & ~rx_ready;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n    = par_bad;
        parity_err_n = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                bit_cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (bit_cnt == HALF_CNT) begin
                    bit_cnt_n = '0;
                    idx_n     = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = '0;
                    shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                    idx_n     = idx + 1'b1;
                    if (idx == LAST_IDX) state_n = S_AFTER_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = '0;
                    par_bad_n = rx_s ^ (^shreg) ^ 1'(PARITY_ODD);
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = '0;
                    state_n   = S_IDLE;
                    if (!rx_s) begin
                        frame_err_n = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad) begin
                        parity_err_n = 1'b1;
                    end
`endif
                    else if (!rx_valid || rx_ready) begin
                        rx_data_n  = shreg;
                        rx_valid_n = 1'b1;
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
            end
            default: begin
                bit_cnt_n = '0;
                state_n   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_n;
            parity_err <= parity_err_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
